// File: rtl/complex_pkg.sv
// Shared widths and state encoding for the complex arithmetic datapath family
// (complex_mult, complex_div).
package complex_pkg;

  // Full-precision width of a sum/difference of two WIDTH x WIDTH signed products.
  function automatic int pw(input int width);
    return 2 * width + 1;
  endfunction

  // Signed quotient width of complex_div; also its divider iteration count.
  function automatic int qw(input int width, input int frac);
    return 2 * width + 1 + frac;
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    SIGN
  } state_t;

endpackage

// File: rtl/complex_div_serial_udiv.sv
// Unsigned radix-2 restoring divider, one quotient bit per step.
// The numerator shifts out of the top of quo while quotient bits shift in at
// the bottom, so after NW steps quo holds num / den.
module serial_udiv #(
  parameter int NW = 41,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic          busy,
  input  logic [NW-1:0] num,
  input  logic [DW-1:0] den,
  output logic [NW-1:0] quo
);

  logic [DW-1:0] rem;
  logic [DW:0]   trial;
  logic [DW:0]   diff;
  logic          fits;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    trial = {rem, quo[NW-1]};
    diff  = trial - {1'b0, den};
    fits  = (trial >= {1'b0, den});
  end

  // Load a fresh numerator, or retire one quotient bit per step.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= num;
    end else if (step && busy) begin
      rem <= fits ? diff[DW-1:0] : trial[DW-1:0];
      quo <= {quo[NW-2:0], fits};
    end
  end

endmodule

// File: rtl/complex_div.sv
// Iterative fixed-point complex divider q = a / b.
// PREP forms both numerators and the denominator at full precision, two serial
// dividers run on the magnitudes for QW cycles, and SIGN restores the signs.
module complex_div
  import complex_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int FRAC  = 8,
  localparam int QW    = qw(WIDTH, FRAC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ab_valid,
  output logic                    ab_ready,
  input  logic signed [WIDTH-1:0] ar,
  input  logic signed [WIDTH-1:0] ai,
  input  logic signed [WIDTH-1:0] br,
  input  logic signed [WIDTH-1:0] bi,
  output logic                    q_valid,
  output logic signed [QW-1:0]    qr,
  output logic signed [QW-1:0]    qi,
  output logic                    dz
);

  localparam int PW = pw(WIDTH);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(QW);

  state_t                  state;
  logic signed [WIDTH-1:0] ar_q, ai_q, br_q, bi_q;
  logic [DW-1:0]           den_q;
  logic                    neg_r, neg_i;
  logic [CW-1:0]           cnt;

  logic signed [PW-1:0]    ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0]    nr, ni;
  logic [PW-1:0]           mag_r, mag_i;
  logic [DW-1:0]           den_c;
  logic [QW-1:0]           num_r, num_i;
  logic [QW-1:0]           quo_r, quo_i;

  // Full-precision numerators, denominator and scaled magnitudes from the captured operands.
  always_comb begin
    ar_x  = PW'(ar_q);
    ai_x  = PW'(ai_q);
    br_x  = PW'(br_q);
    bi_x  = PW'(bi_q);
    nr    = ar_x * br_x + ai_x * bi_x;
    ni    = ai_x * br_x - ar_x * bi_x;
    den_c = DW'(br_x * br_x + bi_x * bi_x);
    mag_r = nr[PW-1] ? -nr : nr;
    mag_i = ni[PW-1] ? -ni : ni;
    num_r = QW'(mag_r) << FRAC;
    num_i = QW'(mag_i) << FRAC;
  end

  serial_udiv #(.NW(QW), .DW(DW)) u_div_r (
    .clk  (clk),
    .rst  (rst),
    .load (state == PREP),
    .step (state == DIV),
    .busy (state != IDLE),
    .num  (num_r),
    .den  (den_q),
    .quo  (quo_r)
  );

  serial_udiv #(.NW(QW), .DW(DW)) u_div_i (
    .clk  (clk),
    .rst  (rst),
    .load (state == PREP),
    .step (state == DIV),
    .busy (state != IDLE),
    .num  (num_i),
    .den  (den_q),
    .quo  (quo_i)
  );

  // Control FSM with registered handshake and result outputs.
  // NOTE: the operand and sign registers are ordinary flops, not a memory, so
  // they are cleared by the asynchronous reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ab_ready <= 1'b1;
      q_valid  <= 1'b0;
      qr       <= '0;
      qi       <= '0;
      dz       <= 1'b0;
      ar_q     <= '0;
      ai_q     <= '0;
      br_q     <= '0;
      bi_q     <= '0;
      den_q    <= '0;
      neg_r    <= 1'b0;
      neg_i    <= 1'b0;
      cnt      <= '0;
    end else begin
      q_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ab_valid) begin
            ar_q     <= ar;
            ai_q     <= ai;
            br_q     <= br;
            bi_q     <= bi;
            ab_ready <= 1'b0;
            state    <= PREP;
          end
        end
        PREP: begin
          den_q <= den_c;
          neg_r <= nr[PW-1];
          neg_i <= ni[PW-1];
          cnt   <= CW'(QW - 1);
          state <= DIV;
        end
        DIV: begin
          if (cnt == '0) begin
            state <= SIGN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SIGN: begin
          if (den_q == '0) begin
            qr <= '0;
            qi <= '0;
            dz <= 1'b1;
          end else begin
            qr <= neg_r ? -quo_r : quo_r;
            qi <= neg_i ? -quo_i : quo_i;
            dz <= 1'b0;
          end
          q_valid  <= 1'b1;
          ab_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Self-checking bench for complex_div at WIDTH=4, FRAC=4.
// A cycle model built from plain integer complex division runs alongside the
// DUT and is compared every cycle; directed operations also check literals.
module tb_complex_div;

  localparam int W   = 4;
  localparam int F   = 4;
  localparam int QW  = 2 * W + 1 + F;
  localparam int LAT = QW + 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                ab_valid;
  logic                ab_ready;
  logic signed [W-1:0] ar, ai, br, bi;
  logic                q_valid;
  logic signed [QW-1:0] qr, qi;
  logic                dz;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  complex_div #(.WIDTH(W), .FRAC(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .ab_valid (ab_valid),
    .ab_ready (ab_ready),
    .ar       (ar),
    .ai       (ai),
    .br       (br),
    .bi       (bi),
    .q_valid  (q_valid),
    .qr       (qr),
    .qi       (qi),
    .dz       (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference quotient: exact complex division scaled by 2^F, truncated toward zero.
  function automatic int exp_q(input bit im, input int a_r, input int a_i,
                               input int b_r, input int b_i);
    int n, d;
    d = b_r * b_r + b_i * b_i;
    if (d == 0) return 0;
    n = im ? (a_i * b_r - a_r * b_i) : (a_r * b_r + a_i * b_i);
    return (n * (1 << F)) / d;
  endfunction

  function automatic bit exp_dz(input int b_r, input int b_i);
    return (b_r * b_r + b_i * b_i) == 0;
  endfunction

  // Cycle model: busy countdown from acceptance to the result pulse.
  int m_cnt, m_qr, m_qi, p_qr, p_qi;
  bit m_qv, m_dz, p_dz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0;
      m_qv  <= 1'b0;
      m_qr  <= 0;
      m_qi  <= 0;
      m_dz  <= 1'b0;
    end else begin
      m_qv <= 1'b0;
      if (m_cnt == 0) begin
        if (ab_valid === 1'b1) begin
          p_qr  <= exp_q(1'b0, ar, ai, br, bi);
          p_qi  <= exp_q(1'b1, ar, ai, br, bi);
          p_dz  <= exp_dz(br, bi);
          m_cnt <= LAT;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_qv <= 1'b1;
          m_qr <= p_qr;
          m_qi <= p_qi;
          m_dz <= p_dz;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_ab_ready", ab_ready, longint'(m_cnt == 0));
      check("cyc_q_valid", q_valid, longint'(m_qv));
      check("cyc_qr", qr, m_qr);
      check("cyc_qi", qi, m_qi);
      check("cyc_dz", dz, longint'(m_dz));
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ab_ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check($sformatf("%s_ready_wait", name), ab_ready, 1);
  endtask

  task automatic run_op(input string name, input int a_r, input int a_i,
                        input int b_r, input int b_i,
                        input int e_qr, input int e_qi, input bit e_dz);
    int n;
    bit seen, low_ok;
    wait_ready(name);
    ar = a_r[W-1:0];
    ai = a_i[W-1:0];
    br = b_r[W-1:0];
    bi = b_i[W-1:0];
    ab_valid = 1'b1;
    @(posedge clk);
    #1;
    ab_valid = 1'b0;
    n = 0;
    seen = 1'b0;
    low_ok = 1'b1;
    while (!seen && n < 40) begin
      if (q_valid === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (ab_ready !== 1'b0) low_ok = 1'b0;
        @(posedge clk);
        #1;
        n++;
      end
    end
    check($sformatf("%s_latency", name), n, LAT);
    check($sformatf("%s_ready_low", name), low_ok, 1);
    check($sformatf("%s_qr", name), qr, e_qr);
    check($sformatf("%s_qi", name), qi, e_qi);
    check($sformatf("%s_dz", name), dz, longint'(e_dz));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst = 1'b1;
    ab_valid = 1'b0;
    ar = '0;
    ai = '0;
    br = '0;
    bi = '0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ab_ready", ab_ready, 1);
    check("rst_q_valid", q_valid, 0);
    check("rst_qr", qr, 0);
    check("rst_qi", qi, 0);
    check("rst_dz", dz, 0);
    rst = 1'b0;

    // Pin the reference model to hand-derived values.
    check("model_basic_qr", exp_q(1'b0, 3, 1, 1, 1), 32);
    check("model_basic_qi", exp_q(1'b1, 3, 1, 1, 1), -16);
    check("model_trunc_qi", exp_q(1'b1, 1, 0, 0, 3), -5);
    check("model_ext_qi", exp_q(1'b1, -8, -8, -8, 0), 16);

    run_op("basic",   3,  1,  1, 1,  32, -16, 1'b0);
    run_op("trunc",   1,  0,  0, 3,   0,  -5, 1'b0);
    run_op("ext_neg", -8, -8, -8, 0, 16,  16, 1'b0);
    run_op("ext_pos", 7,  0,  1, 0, 112,   0, 1'b0);
    run_op("divzero", 5, -3,  0, 0,   0,   0, 1'b1);
    run_op("dz_clear", 2, 0,  1, 0,  32,   0, 1'b0);

    // Continuous ab_valid with operands changing every cycle.
    wait_ready("hs");
    ab_valid = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * (QW + 3); i++) begin
      ar = W'(i * 3 + 1);
      ai = W'(i * 5);
      br = W'(i + 2);
      bi = W'(7 - i);
      @(posedge clk);
      #1;
      if (q_valid === 1'b1) pulses++;
    end
    ab_valid = 1'b0;
    check("hs_pulses", pulses, 3);

    // Reset in the middle of a division aborts it.
    run_op("pre_rst", 3, 1, 1, 1, 32, -16, 1'b0);
    wait_ready("rst_op");
    ar = 4'sd3;
    ai = 4'sd1;
    br = 4'sd1;
    bi = 4'sd1;
    ab_valid = 1'b1;
    @(posedge clk);
    #1;
    ab_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_qr", qr, 0);
    check("mid_rst_qi", qi, 0);
    check("mid_rst_dz", dz, 0);
    check("mid_rst_q_valid", q_valid, 0);
    check("mid_rst_ab_ready", ab_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ab_ready", ab_ready, 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (q_valid === 1'b1) pulses++;
    end
    check("post_rst_no_pulse", pulses, 0);
    run_op("after_rst", 3, 1, 1, 1, 32, -16, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
